// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - RV64 memory-stage load/store unit with a single outstanding data-memory request
module mem_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rd,
    input  logic        in_wr,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [4:0]  in_rd_idx,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [63:0] dmem_req_addr,
    output logic [63:0] dmem_req_wdata,
    output logic [7:0]  dmem_req_be,
    input  logic        dmem_rsp_valid,
    input  logic [63:0] dmem_rsp_rdata,
    output logic        out_valid,
    output logic        out_wen,
    output logic [4:0]  out_rd_idx,
    output logic [63:0] out_data,
    output logic        out_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [2:0]  off_q;
    logic        load_q;
    logic [4:0]  idx_q;

    logic        misaligned;
    logic        illegal;
    logic [7:0]  be_c;
    logic [63:0] shifted;
    logic [63:0] load_c;

    assign in_ready = (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        be_c       = 8'hFF;
        case (in_size)
            2'd0: be_c = 8'h01 << in_addr[2:0];
            2'd1: begin
                misaligned = in_addr[0];
                be_c       = 8'h03 << in_addr[2:0];
            end
            2'd2: begin
                misaligned = |in_addr[1:0];
                be_c       = 8'h0F << in_addr[2:0];
            end
            default: begin
                misaligned = |in_addr[2:0];
                be_c       = 8'hFF;
            end
        endcase
        // Loads always fetch the whole doubleword; lane selection happens on return.
        if (!in_wr) be_c = 8'hFF;
        illegal = (in_rd == in_wr) || misaligned;
    end

    always_comb begin
        shifted = dmem_rsp_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_c = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
            2'd1:    load_c = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
            2'd2:    load_c = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
            default: load_c = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            size_q         <= 2'd0;
            uns_q          <= 1'b0;
            off_q          <= 3'd0;
            load_q         <= 1'b0;
            idx_q          <= 5'd0;
            dmem_req_valid <= 1'b0;
            dmem_req_we    <= 1'b0;
            dmem_req_addr  <= 64'd0;
            dmem_req_wdata <= 64'd0;
            dmem_req_be    <= 8'd0;
            out_valid      <= 1'b0;
            out_wen        <= 1'b0;
            out_err        <= 1'b0;
            out_rd_idx     <= 5'd0;
            out_data       <= 64'd0;
        end else begin
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= 64'd0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (illegal) begin
                            out_valid  <= 1'b1;
                            out_err    <= 1'b1;
                            out_rd_idx <= in_rd_idx;
                        end else begin
                            state          <= REQ;
                            size_q         <= in_size;
                            uns_q          <= in_unsigned;
                            off_q          <= in_addr[2:0];
                            load_q         <= in_rd;
                            idx_q          <= in_rd_idx;
                            dmem_req_valid <= 1'b1;
                            dmem_req_we    <= in_wr;
                            dmem_req_addr  <= {in_addr[63:3], 3'b000};
                            dmem_req_wdata <= in_wdata << {in_addr[2:0], 3'b000};
                            dmem_req_be    <= be_c;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        state      <= IDLE;
                        out_valid  <= 1'b1;
                        out_wen    <= load_q;
                        out_rd_idx <= idx_q;
                        out_data   <= load_q ? load_c : 64'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit for the RV64 pipeline. It accepts one load or store per transaction from the EX stage: the effective address and store data computed by the EX ALU. It drives a single-outstanding valid/ready request to data memory, waits for the response, and returns a sign- or zero-extended load result or a store completion to write-back. It performs byte-lane alignment, byte-enable generation and misalignment detection.

## Interface
- No parameters; data path fixed at 64 bits, address at 64 bits.
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX presents a memory op
- in_ready  out  1  unit can accept (high only in IDLE)
- in_rd / in_wr  in  1 / 1  load / store select
- in_size  in  2  0=B, 1=H, 2=W, 3=D
- in_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- in_addr  in  64  effective address (rs1 + imm)
- in_wdata  in  64  store data (rs2), least-significant bytes used
- in_rd_idx  in  5  destination register
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1=write
- dmem_req_addr  out  64  in_addr with [2:0] forced to 0
- dmem_req_wdata  out  64  in_wdata << 8*in_addr[2:0]
- dmem_req_be  out  8  byte enables (all ones for loads)
- dmem_rsp_valid  in  1  response/ack, one cycle
- dmem_rsp_rdata  in  64  doubleword read data
- out_valid  out  1  one-cycle result pulse to WB
- out_wen  out  1  write register file
- out_rd_idx  out  5  destination register
- out_data  out  64  extended load data
- out_err  out  1  misaligned or illegal op, pulses with out_valid

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - in_valid & in_ready captures all in_* fields into registers.
  - Legal op → REQ.
  - Illegal op: in_rd==in_wr, or addr not aligned to size (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0).
  - Illegal op → stays IDLE. Next cycle out_valid=1, out_err=1, out_wen=0, out_data=0. No memory request is issued.
- REQ: dmem_req_valid=1 with registered fields stable until dmem_req_ready. Handshake → WAIT.
- WAIT:
  - dmem_rsp_valid → IDLE.
  - Next cycle out_valid=1, out_rd_idx=captured index, out_err=0.
  - Load: out_wen=1. Store: out_wen=0, out_data=0.
  - dmem_rsp_valid is ignored in IDLE and REQ.
- Store byte enables, with off = addr[2:0]:
  - B: 8'h01<<off
  - H: 8'h03<<off
  - W: 8'h0F<<off
  - D: 8'hFF
- Load extraction:
  - s = dmem_rsp_rdata >> 8*off.
  - Take the low 8/16/32/64 bits by size.
  - Sign-extend from the top bit unless in_unsigned. in_unsigned is ignored for D.
- x0 destination is not special-cased here; write-back discards it.

## Timing
- Reset values: state=IDLE, dmem_req_valid=0, dmem_req_we=0, dmem_req_addr=0, dmem_req_wdata=0, dmem_req_be=0, out_valid=0, out_wen=0, out_err=0, out_rd_idx=0, out_data=0.
- in_ready is combinational (state==IDLE) and reads 1 during reset, but nothing is captured while rst_n is low.
- Best-case latency, with accept at cycle T:
  - req handshake T+1
  - rsp T+2
  - out_valid T+3
  - next accept possible at T+3, so throughput is one op per 3 cycles minimum.
- Each extra cycle of dmem_req_ready low or response delay adds one cycle. There is no timeout.
- Illegal op latency: out_valid at T+1; next accept at T+1.
- out_* are registered pulses held exactly one cycle. WB applies no backpressure.
- Reset asserted in REQ or WAIT:
  - Aborts immediately to IDLE; outputs go to reset values asynchronously.
  - A late dmem_rsp_valid after reset release arrives in IDLE and is ignored.

## Test plan
- LB: in_addr=0x1003, rdata=0x1122_3344_8566_7788 → req_addr=0x1000, be=8'hFF, out_data=0xFFFF_FFFF_FFFF_FF85, out_wen=1, out_valid at T+3.
- LHU/LW/LD: same rdata, addr 0x1006 LHU → 0x1122. Addr 0x1004 LW → 0x0000_0000_1122_3344. LD at 0x1000 → full word.
- SH: in_addr=0x2002, wdata=0xABCD → be=8'h0C, wdata=0x0000_0000_ABCD_0000, we=1. On ack: out_valid=1, out_wen=0.
- Backpressure: hold dmem_req_ready low 4 cycles, then respond after 3 more → request fields stable throughout, in_ready=0 throughout, single out_valid.
- Misalign/illegal: LW at 0x3002, and an op with in_rd=in_wr=1 → no dmem_req_valid, out_valid and out_err at T+1, out_wen=0.
- Reset in WAIT, then dmem_rsp_valid one cycle after release → outputs at reset values, no out_valid. A following LD completes normally.
